// File: rtl/prescription_pkg.sv
// prescription_pkg: shared types and constants for the prescription
// reminder blocks (scheduler and display path).
package prescription_pkg;

    localparam int unsigned SECS_PER_DAY = 86400;
    localparam int unsigned MAX_INTERVAL = SECS_PER_DAY - 1;

    // Width that holds any value up to MAX_INTERVAL.
    localparam int unsigned SEC_W      = 17;
    // Storage width of the per-channel miss field; the scheduler saturates
    // it at its own MISS_W (which must not exceed this).
    localparam int unsigned MISS_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    typedef logic [SEC_W-1:0] sec_t;

    typedef struct packed {
        logic                  en;
        sec_t                  interval;
        sec_t                  remaining;
        logic                  alarm;
        logic [MISS_MAX_W-1:0] miss;
    } channel_t;

    // {H1,H0,M1,M0,S1,S0}, one BCD digit per nibble.
    typedef logic [23:0] bcd_hms_t;

    // Limit a seconds value to one day minus one second.
    function automatic sec_t clamp_sec(input logic [31:0] s);
        return (s > MAX_INTERVAL) ? sec_t'(MAX_INTERVAL) : s[SEC_W-1:0];
    endfunction

endpackage

// File: rtl/multi_dose_scheduler_sec_to_bcd_hms.sv
// sec_to_bcd_hms: combinational seconds -> BCD HH:MM:SS converter.
// Also used by the display layer.
module sec_to_bcd_hms
    import prescription_pkg::*;
(
    input  sec_t     seconds,
    output bcd_hms_t bcd
);

    logic [31:0] total;
    logic [31:0] hh;
    logic [31:0] mm;
    logic [31:0] ss;

    // Split into hours/minutes/seconds, then each into tens and units.
    always_comb begin
        total = 32'(seconds);
        hh    = total / 32'd3600;
        mm    = (total % 32'd3600) / 32'd60;
        ss    = total % 32'd60;
        bcd   = {4'(hh / 32'd10), 4'(hh % 32'd10),
                 4'(mm / 32'd10), 4'(mm % 32'd10),
                 4'(ss / 32'd10), 4'(ss % 32'd10)};
    end

endmodule

// File: rtl/multi_dose_scheduler.sv
// multi_dose_scheduler: N-channel dose-interval countdown with alarms,
// missed-dose counters and a BCD view of the selected channel.
// Optional feature macro: SNOOZE_EN (snooze reloads the alarmed channel
// with SNOOZE_SEC seconds); without it the snooze input is ignored.
module multi_dose_scheduler
    import prescription_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned TICK_DIV   = 50000000,
    parameter  int unsigned INTERVAL_W = 17,
    parameter  int unsigned MISS_W     = 4,
    parameter  int unsigned SNOOZE_SEC = 300,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [CH_W-1:0]       load_ch,
    input  logic [INTERVAL_W-1:0] load_interval,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  ack,
    input  logic                  snooze,
    input  logic [CH_W-1:0]       sel_ch,
    output logic                  running,
    output logic [NUM_CH-1:0]     alarm,
    output logic                  alarm_valid,
    output logic [CH_W-1:0]       alarm_id,
    output logic [23:0]           disp_hms,
    output logic [MISS_W-1:0]     miss_count
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [MISS_MAX_W-1:0] MISS_SAT = MISS_MAX_W'((1 << MISS_W) - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              running_q;
    channel_t          ch_q [NUM_CH];
    channel_t          ch_d [NUM_CH];

    logic              tick;
    logic [NUM_CH-1:0] alarm_vec;
    logic [CH_W-1:0]   alarm_id_c;
    logic              alarm_found;
    channel_t          sel_c;
    sec_t              sel_remaining;
    bcd_hms_t          sel_bcd;
    sec_t              load_value;

`ifdef SNOOZE_EN
    localparam sec_t SNOOZE_RELOAD = clamp_sec(32'(SNOOZE_SEC));
`else
    logic [32:0] snooze_unused;
    assign snooze_unused = {snooze, 32'(SNOOZE_SEC)};
`endif

    assign tick       = (state_q == RUN) && (div_q == DIV_LAST);
    assign load_value = clamp_sec(32'(load_interval));

    // Global run state and 1 Hz divider next-state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        if (state_q == RUN) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start && !pause) begin
                    state_d = RUN;
                    div_d   = '0;
                end
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (start && !pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending alarm vector and lowest-index pending channel.
    always_comb begin
        alarm_vec   = '0;
        alarm_id_c  = '0;
        alarm_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            alarm_vec[i] = ch_q[i].alarm;
            if (ch_q[i].alarm && !alarm_found) begin
                alarm_id_c  = CH_W'(i);
                alarm_found = 1'b1;
            end
        end
    end

    assign alarm       = alarm_vec;
    assign alarm_valid = alarm_found;
    assign alarm_id    = alarm_id_c;

    // Per-channel update; later assignments win, so the code runs from
    // lowest to highest priority: ack, snooze, expiry, load.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            logic ack_hit;
            logic expire;
            ch_d[i] = ch_q[i];
            ack_hit = ack && alarm_found && (alarm_id_c == CH_W'(i));
            expire  = tick && ch_q[i].en && (ch_q[i].remaining == sec_t'(1));

            if (tick && ch_q[i].en && (ch_q[i].remaining > sec_t'(1))) begin
                ch_d[i].remaining = ch_q[i].remaining - sec_t'(1);
            end

            if (ack_hit) begin
                ch_d[i].alarm = 1'b0;
            end

`ifdef SNOOZE_EN
            if (snooze && alarm_found && (alarm_id_c == CH_W'(i))) begin
                ch_d[i].alarm     = 1'b0;
                ch_d[i].remaining = SNOOZE_RELOAD;
            end
`endif

            // A same-cycle ack consumes the old alarm, so it is not a miss.
            if (expire) begin
                ch_d[i].remaining = ch_q[i].interval;
                ch_d[i].alarm     = 1'b1;
                if (ch_q[i].alarm && !ack_hit && (ch_q[i].miss != MISS_SAT)) begin
                    ch_d[i].miss = ch_q[i].miss + 1'b1;
                end
            end

            if (load && (load_ch == CH_W'(i))) begin
                if (load_interval == '0) begin
                    ch_d[i] = '0;
                end else begin
                    ch_d[i].en        = 1'b1;
                    ch_d[i].interval  = load_value;
                    ch_d[i].remaining = load_value;
                    ch_d[i].alarm     = 1'b0;
                    ch_d[i].miss      = '0;
                end
            end
        end
    end

    // Selected channel view; out-of-range or disabled channels read as 0.
    always_comb begin
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == sel_ch) begin
                sel_c = ch_q[i];
            end
        end
        sel_remaining = sel_c.en ? sel_c.remaining : '0;
        miss_count    = sel_c.en ? sel_c.miss[MISS_W-1:0] : '0;
    end

    sec_to_bcd_hms u_sec_to_bcd (
        .seconds (sel_remaining),
        .bcd     (sel_bcd)
    );

    assign disp_hms = sel_bcd;
    assign running  = running_q;

    // State, divider and channel registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            running_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            running_q <= (state_d == RUN);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_dose_scheduler.sv
// tb_multi_dose_scheduler: directed and random checks of multi_dose_scheduler
// against a behavioural model. Build with +define+SNOOZE_EN for the snooze variant.
module tb_multi_dose_scheduler;

    localparam int NCH = 4;
    localparam int TD  = 4;
    localparam int MW  = 2;
    localparam int SNZ = 5;
    localparam int unsigned MISS_TOP = (1 << MW) - 1;
`ifdef SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, load, start, pause, ack, snooze;
    logic [1:0]  load_ch, sel_ch;
    logic [16:0] load_interval;
    logic        running, alarm_valid;
    logic [3:0]  alarm;
    logic [1:0]  alarm_id;
    logic [23:0] disp_hms;
    logic [1:0]  miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: plain per-channel quantities and a run mode (0 idle, 1 run, 2 paused).
    bit          m_en  [NCH];
    bit          m_al  [NCH];
    int unsigned m_int [NCH];
    int unsigned m_rem [NCH];
    int unsigned m_miss[NCH];
    int          m_mode = 0;
    int unsigned m_div  = 0;

    multi_dose_scheduler #(
        .NUM_CH     (NCH),
        .TICK_DIV   (TD),
        .INTERVAL_W (17),
        .MISS_W     (MW),
        .SNOOZE_SEC (SNZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_ch       (load_ch),
        .load_interval (load_interval),
        .start         (start),
        .pause         (pause),
        .ack           (ack),
        .snooze        (snooze),
        .sel_ch        (sel_ch),
        .running       (running),
        .alarm         (alarm),
        .alarm_valid   (alarm_valid),
        .alarm_id      (alarm_id),
        .disp_hms      (disp_hms),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int unsigned s);
        int unsigned h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit          valid;
        int unsigned id;
        bit          tk;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_al[c] = 0; m_int[c] = 0; m_rem[c] = 0; m_miss[c] = 0;
            end
            m_mode = 0;
            m_div  = 0;
            return;
        end
        valid = 0;
        id    = 0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (m_al[c]) begin
                valid = 1;
                id    = c;
            end
        end
        tk = (m_mode == 1) && (m_div == TD - 1);
        for (int c = 0; c < NCH; c++) begin
            bit picked;
            picked = valid && (id == c);
            if (load && (load_ch == c)) begin
                if (load_interval == 0) begin
                    m_en[c] = 0; m_al[c] = 0; m_int[c] = 0; m_rem[c] = 0; m_miss[c] = 0;
                end else begin
                    m_en[c]   = 1;
                    m_int[c]  = (load_interval > 86399) ? 86399 : load_interval;
                    m_rem[c]  = m_int[c];
                    m_al[c]   = 0;
                    m_miss[c] = 0;
                end
            end else if (tk && m_en[c] && m_rem[c] == 1) begin
                if (m_al[c] && !(ack && picked))
                    m_miss[c] = (m_miss[c] + 1 > MISS_TOP) ? MISS_TOP : m_miss[c] + 1;
                m_al[c]  = 1;
                m_rem[c] = m_int[c];
            end else begin
                if (tk && m_en[c]) m_rem[c] = m_rem[c] - 1;
                if (SNOOZE_ON && snooze && picked) begin
                    m_al[c]  = 0;
                    m_rem[c] = SNZ;
                end else if (ack && picked) begin
                    m_al[c] = 0;
                end
            end
        end
        if (m_mode == 1) m_div = (m_div == TD - 1) ? 0 : m_div + 1;
        if (pause) begin
            if (m_mode == 1) m_mode = 2;
        end else if (start && m_mode != 1) begin
            if (m_mode == 0) m_div = 0;
            m_mode = 1;
        end
    endtask

    task automatic check_all();
        logic [3:0]  ea;
        int unsigned eid;
        ea  = '0;
        eid = 0;
        for (int c = NCH - 1; c >= 0; c--) begin
            ea[c] = m_al[c];
            if (m_al[c]) eid = c;
        end
        check("running", running, (m_mode == 1));
        check("alarm", alarm, ea);
        check("alarm_valid", alarm_valid, |ea);
        check("alarm_id", alarm_id, eid);
        check("disp_hms", disp_hms, m_en[sel_ch] ? to_bcd(m_rem[sel_ch]) : 24'h0);
        check("miss_count", miss_count, m_en[sel_ch] ? m_miss[sel_ch] : 0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        load = 0; start = 0; pause = 0; ack = 0; snooze = 0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [16:0] val);
        load = 1; load_ch = ch; load_interval = val;
        cycle();
    endtask

    initial begin
        reset = 1; load = 0; start = 0; pause = 0; ack = 0; snooze = 0;
        load_ch = 0; load_interval = 0; sel_ch = 0;

        // Reset state
        cycle();
        cycle();
        reset = 0;
        check("rst_alarm", alarm, 4'h0);
        check("rst_running", running, 1'b0);
        check("rst_disp", disp_hms, 24'h0);

        // First expiry: interval 3, alarm after the third tick
        do_reset();
        sel_ch = 0;
        do_load(0, 3);
        start = 1;
        cycle();
        repeat (11) cycle();
        check("first_alarm_early", alarm[0], 1'b0);
        cycle();
        check("first_alarm", alarm, 4'b0001);
        check("first_id", alarm_id, 2'd0);
        check("first_reload", disp_hms, 24'h000003);

        // Two channels expire together, acked lowest first
        do_reset();
        do_load(0, 2);
        do_load(2, 2);
        start = 1;
        cycle();
        repeat (8) cycle();
        check("dual_alarm", alarm, 4'b0101);
        check("dual_id0", alarm_id, 2'd0);
        ack = 1;
        cycle();
        check("dual_id2", alarm_id, 2'd2);
        ack = 1;
        cycle();
        check("dual_cleared", alarm_valid, 1'b0);

        // Missed doses and saturation at MISS_W=2
        do_reset();
        sel_ch = 1;
        do_load(1, 2);
        start = 1;
        cycle();
        repeat (24) cycle();
        check("miss_two", miss_count, 2'd2);
        repeat (16) cycle();
        check("miss_sat", miss_count, 2'd3);

        // Clamp, pause freeze and resume
        do_reset();
        sel_ch = 3;
        do_load(3, 17'd90000);
        check("clamp_disp", disp_hms, 24'h235959);
        start = 1;
        cycle();
        repeat (7) cycle();
        pause = 1;
        cycle();
        check("pause_running", running, 1'b0);
        check("pause_disp", disp_hms, 24'h235957);
        repeat (20) cycle();
        check("pause_frozen", disp_hms, 24'h235957);
        start = 1;
        cycle();
        repeat (3) cycle();
        check("resume_early", disp_hms, 24'h235957);
        cycle();
        check("resume_tick", disp_hms, 24'h235956);

        // Ack on an expiry cycle, then load on a tick cycle
        do_reset();
        sel_ch = 0;
        do_load(0, 2);
        start = 1;
        cycle();
        repeat (8) cycle();
        check("ackexp_first", alarm[0], 1'b1);
        repeat (7) cycle();
        ack = 1;
        cycle();
        check("ackexp_alarm", alarm[0], 1'b1);
        check("ackexp_miss", miss_count, 2'd0);
        repeat (3) cycle();
        do_load(0, 5);
        check("load_tick_disp", disp_hms, 24'h000005);
        check("load_tick_alarm", alarm[0], 1'b0);

        // Snooze on a pending alarm
        do_reset();
        sel_ch = 0;
        do_load(0, 2);
        start = 1;
        cycle();
        repeat (8) cycle();
        snooze = 1;
        cycle();
        check("snooze_alarm", alarm[0], SNOOZE_ON ? 1'b0 : 1'b1);
        check("snooze_disp", disp_hms, SNOOZE_ON ? 24'h000005 : 24'h000002);

        // Disable by loading zero
        do_load(0, 0);
        check("disable_disp", disp_hms, 24'h0);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                load    = 1;
                load_ch = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) load_interval = 17'($urandom_range(0, 131071));
                else load_interval = 17'($urandom_range(0, 7));
            end
            start  = ($urandom_range(0, 9) == 0);
            pause  = ($urandom_range(0, 19) == 0);
            ack    = ($urandom_range(0, 5) == 0);
            snooze = ($urandom_range(0, 11) == 0);
            if ((n % 8) == 0) sel_ch = 2'($urandom_range(0, 3));
            reset  = ($urandom_range(0, 399) == 0);
            cycle();
            reset = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_dose_scheduler.md
Name: multi_dose_scheduler

Overview:
Parametrised N-channel successor to the single-prescription reminder. Each channel holds a dose interval in seconds and counts it down from an internal 1 Hz tick. On expiry the channel raises an alarm and auto-reloads, and unacknowledged expiries count as missed doses. The block feeds the existing seven-segment display path: BCD HH:MM:SS of a selected channel plus the pending alarm ID. It sits between the shaped-button/control layer and the SevenSegDisp instances.

Parameters:
NUM_CH, 4, number of prescription channels (1..16)
TICK_DIV, 50000000, clk cycles per 1 s tick
INTERVAL_W, 17, interval/remaining width in seconds (max loadable 86399)
MISS_W, 4, per-channel missed-dose counter width
SNOOZE_SEC, 300, snooze reload value in seconds (SNOOZE_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle pulse: program channel load_ch
load_ch  in  CH_W=max(1,$clog2(NUM_CH))  channel to program
load_interval  in  INTERVAL_W  interval in seconds; 0 disables the channel
start  in  1  one-cycle pulse: run countdown
pause  in  1  one-cycle pulse: freeze countdown
ack  in  1  one-cycle pulse: acknowledge alarm_id
snooze  in  1  one-cycle pulse: snooze alarm_id (ignored without SNOOZE_EN)
sel_ch  in  CH_W  channel shown on disp_hms/miss_count
running  out  1  1 in RUN state
alarm  out  NUM_CH  per-channel pending alarm
alarm_valid  out  1  OR of alarm
alarm_id  out  CH_W  lowest-index pending alarm; 0 if none
disp_hms  out  24  BCD {H1,H0,M1,M0,S1,S0} of remaining[sel_ch]
miss_count  out  MISS_W  missed-dose count of sel_ch

Behaviour:
- Reset, synchronous and overriding all other inputs: state=IDLE; all channels disabled; interval, remaining, alarm and miss all 0; divider 0. All outputs are 0.
- Global FSM states are IDLE, RUN and PAUSED.
  - start in IDLE or PAUSED moves to RUN.
  - pause in RUN moves to PAUSED.
  - start and pause in the same cycle: pause wins (IDLE stays IDLE).
- Divider counts 0..TICK_DIV-1 only in RUN, holds in IDLE/PAUSED, and is cleared on the IDLE-to-RUN transition. tick is a 1-cycle internal pulse at terminal count; the first tick occurs TICK_DIV cycles after start.
- load, in any state: channel enabled; interval=remaining=min(load_interval, 86399); alarm and miss cleared. load_interval=0 disables the channel and clears all four fields. Takes effect the next cycle. load_ch>=NUM_CH is ignored.
- On tick, per enabled channel:
  - remaining>1: decrement.
  - remaining==1: remaining<=interval, alarm<=1; if alarm was already 1, miss<=miss+1, saturating at all-ones.
- Alarm appears one cycle after the expiring tick.
- ack clears alarm[alarm_id]; ignored when alarm_valid=0. Miss is unchanged.
- Same-cycle priority per channel: reset > load > expiry > snooze > ack.
  - Ack plus expiry on the same channel: alarm stays 1 and miss is NOT incremented, because the old alarm is consumed.
- alarm_valid and alarm_id are combinational from the alarm register (0-cycle latency after alarm).
- disp_hms and miss_count are combinational from the selected registers. Both show 0 if sel_ch>=NUM_CH or the channel is disabled. disp_hms is valid BCD for 0..86399 (23:59:59).
- PAUSED and IDLE freeze remaining. Alarms persist and ack remains active.

Optional Feature:
SNOOZE_EN
- Defined: snooze with alarm_valid clears alarm[alarm_id] and sets that channel's remaining to SNOOZE_SEC (clamped to 86399). interval and miss are unchanged. The next expiry reloads from interval as usual.
- Undefined: snooze port exists but is ignored, and no snooze logic is built.

Decomposition:
- Shared package prescription_pkg:
  - SECS_PER_DAY=86400, MAX_INTERVAL=86399
  - state_t enum {IDLE,RUN,PAUSED}
  - channel record typedef (en, interval, remaining, alarm, miss)
  - bcd_hms_t (24-bit packed)
- Sub-module sec_to_bcd_hms: purely combinational; seconds to HH:MM:SS BCD via /3600, /60 and digit split. It is reused later by the display layer.
- Channel array and priority encoder stay in the top module.

Test Plan:
- TICK_DIV=4: reset, load ch0=3, start → alarm[0]=1 on the cycle after the 3rd tick (13th cycle after start); remaining reloads to 3; alarm_id=0.
- ch0 and ch2 expire on the same tick → alarm=4'b0101, alarm_id=0. ack → alarm_id=2. ack → alarm_valid=0.
- Let ch1 (interval 2) expire 3 times without ack → miss_count(sel_ch=1)=2. With MISS_W=2 and 5 unacked expiries, miss saturates at 3.
- load ch3=90000, sel_ch=3 → disp_hms=24'h235959. pause freezes the value across 20 cycles. start resumes with the next tick 4 cycles later.
- ack on the expiry cycle of ch0 (alarm already set) → alarm[0] stays 1, miss unchanged. load on a tick cycle → remaining=new value, not decremented.
- SNOOZE_EN, SNOOZE_SEC=5: snooze on ch0 alarm → alarm[0]=0, disp_hms=24'h000005. Without the macro the same stimulus leaves alarm[0]=1.
